pipe_queue_64: RTL

Ready/valid FIFO in pipe mode, the backward-bypass counterpart to the flow-mode queues used on the TileLink-side data paths. Flow queues pass data forward when empty. This block passes `io_deq_ready` backward when full, so a full queue accepts a new beat in the same cycle a beat leaves. It sits on the producer side of a consumer stage and keeps full throughput without an extra bubble. Output data always comes from storage, so enqueue to dequeue is never combinational.

---
 rtl/pipe_queue_64_if.sv | 18 +
 rtl/pipe_queue_64.sv | 52 +++++
 2 files changed

// File: rtl/pipe_queue_64_if.sv
// pipe_queue_64_if: ready/valid enqueue/dequeue bundle plus occupancy for pipe_queue_64
interface pipe_queue_64_if #(parameter int WIDTH = 64, parameter int CW = 2);
  logic             io_enq_valid;
  logic [WIDTH-1:0] io_enq_bits_data;
  logic             io_enq_ready;
  logic             io_deq_valid;
  logic [WIDTH-1:0] io_deq_bits_data;
  logic             io_deq_ready;
  logic [CW-1:0]    io_count;
  modport master (
    output io_enq_valid, io_enq_bits_data, io_deq_ready,
    input  io_enq_ready, io_deq_valid, io_deq_bits_data, io_count
  );
  modport slave (
    input  io_enq_valid, io_enq_bits_data, io_deq_ready,
    output io_enq_ready, io_deq_valid, io_deq_bits_data, io_count
  );
endinterface

// File: rtl/pipe_queue_64.sv
// pipe_queue_64: pipe-mode ready/valid FIFO; a full queue accepts a beat when one leaves.
// Define PIPE_QUEUE_COUNT_EN for a live io_count; otherwise io_count is tied to 0.
module pipe_queue_64 #(
  parameter int ENTRIES = 3,
  parameter int WIDTH   = 64,
  localparam int PW     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int CW     = $clog2(ENTRIES + 1)
) (
  input logic            clock,
  input logic            reset,
  pipe_queue_64_if.slave io
);
  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [PW-1:0]    enq_ptr_q, enq_ptr_d, deq_ptr_q, deq_ptr_d;
  logic             maybe_full_q, maybe_full_d;
  logic             ptr_match, empty, full, do_enq, do_deq;
  always_comb begin
    ptr_match           = enq_ptr_q == deq_ptr_q;
    empty               = ptr_match & ~maybe_full_q;
    full                = ptr_match & maybe_full_q;
    io.io_deq_valid     = ~empty;
    io.io_deq_bits_data = mem_q[deq_ptr_q];
    io.io_enq_ready     = ~full | io.io_deq_ready;
    do_enq              = io.io_enq_valid & io.io_enq_ready;
    do_deq              = io.io_deq_valid & io.io_deq_ready;
    enq_ptr_d           = !do_enq ? enq_ptr_q : enq_ptr_q == PW'(ENTRIES - 1) ? '0 : enq_ptr_q + 1'b1;
    deq_ptr_d           = !do_deq ? deq_ptr_q : deq_ptr_q == PW'(ENTRIES - 1) ? '0 : deq_ptr_q + 1'b1;
    maybe_full_d        = (do_enq != do_deq) ? do_enq : maybe_full_q;
  end
`ifdef PIPE_QUEUE_COUNT_EN
  always_comb
    io.io_count = full ? CW'(ENTRIES)
                : (enq_ptr_q >= deq_ptr_q) ? CW'(enq_ptr_q) - CW'(deq_ptr_q)
                : CW'(ENTRIES) + CW'(enq_ptr_q) - CW'(deq_ptr_q);
`else
  assign io.io_count = '0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr_q    <= '0;
      deq_ptr_q    <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end
  // storage is deliberately unreset; pointers alone define what is reachable
  always_ff @(posedge clock)
    if (do_enq) mem_q[enq_ptr_q] <= io.io_enq_bits_data;
endmodule
